// File: rtl/stb_gen_pkg.sv
// Shared types and constants for the multi-channel strobe generator.
package stb_gen_pkg;

  // Fewer stages than this leaves the edge detector exposed to metastability.
  localparam int STB_GEN_MIN_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    MEAS = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } stb_gen_state_e;

  function automatic int sync_depth(input int requested);
    return (requested < STB_GEN_MIN_SYNC_STAGES) ? STB_GEN_MIN_SYNC_STAGES : requested;
  endfunction

endpackage

// File: rtl/stb_gen_ch.sv
// One strobe-generator channel: synchroniser, period-averaging FSM and flywheel strobe.
// Define STB_GEN_JITTER_CHECK_EN to fault a locked channel whose period drifts beyond JIT_TOL.
module stb_gen_ch
  import stb_gen_pkg::*;
#(
  parameter int T_CNT_WIDTH = 32,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int JIT_TOL     = 4
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   sig_i,
  input  logic                   run_det_i,
  input  logic                   oe_i,
  input  logic [T_CNT_WIDTH-1:0] stb_delay_i,
  output logic                   stb_o,
  output logic                   rdy_o,
  output logic                   err_o,
  output logic [T_CNT_WIDTH-1:0] stb_period_o
);

  localparam int SYNC_DEPTH = sync_depth(SYNC_STAGES);
  localparam int SUM_W      = T_CNT_WIDTH + AVG_LOG2;
  localparam int IDX_W      = AVG_LOG2 + 1;
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [T_CNT_WIDTH-1:0] CNT_ONE   = T_CNT_WIDTH'(1);
  localparam logic [T_CNT_WIDTH-1:0] JIT_LIMIT = T_CNT_WIDTH'(JIT_TOL);
`ifdef STB_GEN_JITTER_CHECK_EN
  localparam bit JIT_EN = 1'b1;
`else
  localparam bit JIT_EN = 1'b0;
`endif

  logic [SYNC_DEPTH-1:0]  sync_reg;
  logic                   sync_prev_reg;
  logic                   edge_reg;
  stb_gen_state_e         state_reg, state_next;
  logic [T_CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [SUM_W-1:0]       sum_reg, sum_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [T_CNT_WIDTH-1:0] phase_reg, phase_next;
  logic [T_CNT_WIDTH-1:0] period_reg, period_next;
  logic                   stb_reg, stb_next;

  logic                   cnt_sat;
  logic [SUM_W-1:0]       sum_acc;
  logic [T_CNT_WIDTH-1:0] phase_cur;
  logic                   phase_wrap;
  logic [T_CNT_WIDTH-1:0] jit_diff;
  logic                   jit_bad;

  assign cnt_sat = &cnt_reg;
  assign sum_acc = sum_reg + SUM_W'(cnt_reg);

  // The edge cycle itself is phase 0, so a delay of D lands D cycles after the edge pulse.
  assign phase_cur  = edge_reg ? '0 : phase_reg;
  assign phase_wrap = (phase_cur == period_reg - CNT_ONE);

  assign jit_diff = (cnt_reg > period_reg) ? (cnt_reg - period_reg) : (period_reg - cnt_reg);
  assign jit_bad  = JIT_EN && (jit_diff > JIT_LIMIT);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    sum_next    = sum_reg;
    idx_next    = idx_reg;
    phase_next  = phase_reg;
    period_next = period_reg;
    stb_next    = 1'b0;

    if (!run_det_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: state_next = ARM;

        ARM: begin
          if (edge_reg) begin
            cnt_next   = CNT_ONE;
            sum_next   = '0;
            idx_next   = '0;
            state_next = MEAS;
          end
        end

        MEAS: begin
          if (edge_reg) begin
            sum_next = sum_acc;
            cnt_next = CNT_ONE;
            if (idx_reg == IDX_LAST) begin
              period_next = T_CNT_WIDTH'(sum_acc >> AVG_LOG2);
              idx_next    = '0;
              phase_next  = CNT_ONE;
              state_next  = RUN;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else if (cnt_sat) begin
            state_next = ERR;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end

        RUN: begin
          phase_next = phase_wrap ? '0 : phase_cur + CNT_ONE;
          if (edge_reg) begin
            cnt_next = CNT_ONE;
            if (jit_bad) state_next = ERR;
          end else if (cnt_sat) begin
            state_next = ERR;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end

        ERR: state_next = ERR;

        default: state_next = IDLE;
      endcase
    end

    // A channel leaving RUN this cycle (abort or fault) must not fire a final strobe.
    stb_next = (state_reg == RUN) && (state_next == RUN) && oe_i && (phase_cur == stb_delay_i);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
      edge_reg      <= 1'b0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sum_reg       <= '0;
      idx_reg       <= '0;
      phase_reg     <= '0;
      period_reg    <= '0;
      stb_reg       <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_DEPTH-2:0], sig_i};
      sync_prev_reg <= sync_reg[SYNC_DEPTH-1];
      edge_reg      <= sync_reg[SYNC_DEPTH-1] & ~sync_prev_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sum_reg       <= sum_next;
      idx_reg       <= idx_next;
      phase_reg     <= phase_next;
      period_reg    <= period_next;
      stb_reg       <= stb_next;
    end
  end

  assign stb_o        = stb_reg;
  assign rdy_o        = (state_reg == RUN);
  assign err_o        = (state_reg == ERR);
  assign stb_period_o = period_reg;

endmodule

// File: rtl/stb_gen_mc.sv
// Multi-channel strobe generator: N_CH independent stb_gen_ch instances on sliced buses.
// Jitter fault detection is built in when STB_GEN_JITTER_CHECK_EN is defined.
module stb_gen_mc #(
  parameter int N_CH        = 4,
  parameter int T_CNT_WIDTH = 32,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int JIT_TOL     = 4
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic [N_CH-1:0]               sig_i,
  input  logic [N_CH-1:0]               run_det_i,
  input  logic [N_CH-1:0]               oe_i,
  input  logic [N_CH*T_CNT_WIDTH-1:0]   stb_delay_i,
  output logic [N_CH-1:0]               stb_o,
  output logic [N_CH-1:0]               rdy_o,
  output logic [N_CH-1:0]               err_o,
  output logic [N_CH*T_CNT_WIDTH-1:0]   stb_period_o
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      stb_gen_ch #(
        .T_CNT_WIDTH (T_CNT_WIDTH),
        .AVG_LOG2    (AVG_LOG2),
        .SYNC_STAGES (SYNC_STAGES),
        .JIT_TOL     (JIT_TOL)
      ) u_ch (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .sig_i        (sig_i[gi]),
        .run_det_i    (run_det_i[gi]),
        .oe_i         (oe_i[gi]),
        .stb_delay_i  (stb_delay_i[gi*T_CNT_WIDTH +: T_CNT_WIDTH]),
        .stb_o        (stb_o[gi]),
        .rdy_o        (rdy_o[gi]),
        .err_o        (err_o[gi]),
        .stb_period_o (stb_period_o[gi*T_CNT_WIDTH +: T_CNT_WIDTH])
      );
    end
  endgenerate

endmodule

// File: doc/stb_gen_mc.md
# stb_gen_mc

Multi-channel successor to the single-channel strobe generator, with one independent period detector and strobe generator per channel. Each channel synchronises an asynchronous periodic input and measures its period averaged over 2^AVG_LOG2 periods. It then emits a flywheel strobe, phase-locked to the input edges, at a programmable delay. It sits between the external trigger inputs and the measure-unit capture logic.

## Interface
- N_CH, 4: number of independent channels
- T_CNT_WIDTH, 32: period/phase counter width, in clocks
- AVG_LOG2, 2: log2 of the number of periods averaged (0 means a single period)
- SYNC_STAGES, 2: synchroniser depth on sig_i (minimum 2)
- JIT_TOL, 4: allowed per-period deviation in clocks (used only with jitter check)

- clk_i  in  1  system clock
- arstn_i  in  1  asynchronous, active-low reset
- sig_i  in  N_CH  asynchronous periodic inputs, rising edge is the reference
- run_det_i  in  N_CH  per-channel enable; low aborts the channel and returns it to IDLE
- oe_i  in  N_CH  per-channel strobe output enable
- stb_delay_i  in  N_CH*T_CNT_WIDTH  strobe offset after the edge, in clocks
- stb_o  out  N_CH  one-cycle strobe pulses
- rdy_o  out  N_CH  average period valid; channel in RUN
- err_o  out  N_CH  channel failed; sticky until run_det_i goes low
- stb_period_o  out  N_CH*T_CNT_WIDTH  averaged period, in clocks

## Operation
- Edge detection: SYNC_STAGES flops followed by a registered rising-edge detect.
  - edge pulse is 1 cycle long
  - edge pulse appears SYNC_STAGES+1 cycles after a sig_i rise
- Period definition: number of clk_i cycles between consecutive edge pulses.
- FSM states per channel: IDLE, ARM, MEAS, RUN, ERR.
  - IDLE → ARM when run_det_i=1.
  - ARM: wait for the first edge; on the edge, period counter := 1, sum := 0, idx := 0, go to MEAS.
  - MEAS: counter increments every cycle. On an edge:
    - sum += counter, counter := 1, idx++
    - when idx reaches 2^AVG_LOG2: stb_period_o := sum >> AVG_LOG2 (truncated), rdy_o := 1, go to RUN
  - RUN: counter keeps measuring every period; stb_period_o is not updated.
  - Any state → IDLE when run_det_i=0.
- Sum width is T_CNT_WIDTH+AVG_LOG2 bits; no overflow is possible.
- Saturation: if the counter reaches all-ones without an edge (in MEAS or RUN), go to ERR.
  - err_o := 1, rdy_o := 0, no strobes
  - channel holds in ERR until run_det_i=0
- Strobe phase counter, active in RUN:
  - cleared to 0 on every edge pulse
  - otherwise increments and wraps from stb_period_o-1 to 0 (flywheel across missing edges)
  - stb_delay_i ≥ stb_period_o means no strobe is emitted and no error is raised
- stb_o pulses when phase == stb_delay_i and oe_i=1.
- Return to IDLE clears rdy_o and err_o; stb_period_o holds its last value.
- Channels are fully independent; no shared state.

## Timing
- Reset values: stb_o, rdy_o, err_o and stb_period_o are all 0; FSM in IDLE; synchroniser flops 0.
- rdy_o and stb_period_o update in the cycle after the 2^AVG_LOG2-th edge pulse (registered).
- stb_o is registered: it is high for exactly 1 cycle, the cycle after the phase==stb_delay_i match. oe_i is sampled in the match cycle.
- Edge and wrap in the same cycle: the edge wins, phase := 0.
- run_det_i falls in the same cycle as an edge: abort wins, and the channel is in IDLE next cycle.
- run_det_i low for at least 1 cycle, then high, restarts detection from ARM.
- arstn_i asserted mid-operation returns all outputs to reset values immediately (asynchronous).
- arstn_i deassertion is synchronised externally.

## Configuration
- STB_GEN_JITTER_CHECK_EN defined:
  - in RUN, each new measured period is compared with stb_period_o
  - |diff| > JIT_TOL → ERR (err_o=1, rdy_o=0)
- STB_GEN_JITTER_CHECK_EN undefined: no comparison; JIT_TOL is ignored; only saturation raises err_o.

## Structure
- Package stb_gen_pkg holds:
  - the FSM state enum stb_gen_state_e (IDLE, ARM, MEAS, RUN, ERR)
  - the minimum-synchroniser-depth constant
- Sub-module stb_gen_ch is one complete channel: synchroniser, FSM, counters and strobe logic.
- The top level instantiates stb_gen_ch N_CH times with a generate loop and slices the packed buses.

## Test plan
- Reset: arstn_i=0 with inputs toggling → all outputs 0; release with run_det_i=0 → channels stay IDLE.
- Steady input (AVG_LOG2=2): ch0 period 800 clocks → rdy_o[0] rises the cycle after the 5th edge pulse, stb_period_o[0]=800; other channels unaffected.
- Averaging: alternating 799/801 periods → stb_period_o=800. Alternating 799/800 → 799 (truncation).
- Strobe placement:
  - stb_delay_i=100, oe_i=1 → stb_o 1-cycle pulse 101 cycles after each edge pulse
  - oe_i=0 → no pulses
  - stop sig_i → pulses continue every 800 cycles (flywheel)
- Saturation (T_CNT_WIDTH=12): sig_i stuck low after ARM → err_o=1 when the counter hits 4095. run_det_i low for 2 cycles then high → err_o=0, re-measures.
- Jitter check (STB_GEN_JITTER_CHECK_EN, JIT_TOL=4): lock at 800, then one period of 810 → err_o=1, rdy_o=0. Without the macro: stays in RUN, rdy_o=1.
